scarv_cop_palu_issue: RTL and testbench
=======================================

SCARV_COP_PALU_ISSUE -- requirements
Module: scarv_cop_palu_issue

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter CPR_RESET_VAL, default 32'h0, value loaded into every CPR on reset.
REQ-003 g_clk  input  1  global clock; all state updates on rising edge.
REQ-004 g_reset  input  1  asynchronous active-high reset.
REQ-005 id_valid  input  1  decoded instruction offered by decoder.
REQ-006 id_ready  output  1  block can accept an instruction this cycle.
REQ-007 id_crs1, id_crs2, id_crs3, id_crd  input  4 each  CPR source/destination indices.
REQ-008 id_gpr_rs1  input  32  GPR operand from CPU.
REQ-009 id_imm  input  32; id_pw  input  3; id_class  input  3; id_subclass  input  4  decoded fields.
REQ-010 palu_ivalid  output  1  instruction valid to PALU.
REQ-011 palu_idone  input  1  PALU instruction complete.
REQ-012 gpr_rs1, palu_rs1, palu_rs2, palu_rs3  output  32 each  registered operands to PALU.
REQ-013 palu_imm  output  32; palu_pw  output  3; palu_class  output  3; palu_subclass  output  4  registered fields to PALU.
REQ-014 palu_cpr_rd_ben  input  4  writeback byte enables from PALU.
REQ-015 palu_cpr_rd_wdata  input  32  writeback data from PALU.
REQ-016 flush  input  1  abandon in-flight instruction.
REQ-017 cop_done  output  1  one-cycle completion pulse to CPU.
REQ-018 dbg_addr  input  4; dbg_rdata  output  32  combinational CPR read port.

Function
REQ-019 Block SHALL contain 16 x 32-bit CPRs c0..c15; c0 is an ordinary writable register.
REQ-020 FSM states SHALL be IDLE and EXEC only.
REQ-021 id_ready SHALL be 1 exactly when state is IDLE and flush is 0.
REQ-022 IDLE with id_valid && id_ready at edge T: latch all id_* fields, latch CPR[id_crs1/2/3] into palu_rs1/2/3, latch id_gpr_rs1 into gpr_rs1, enter EXEC at T+1.
REQ-023 CPR reads at accept SHALL see the register contents as of that edge; no bypass is required because a write always completes at least one cycle before the next accept.
REQ-024 palu_ivalid SHALL equal 1 in EXEC and 0 in IDLE; all palu_* operand/field outputs SHALL stay stable throughout EXEC.
REQ-025 EXEC with palu_idone=1 and flush=0: for each lane i with palu_cpr_rd_ben[i]=1, write palu_cpr_rd_wdata[8i+7:8i] into CPR[crd] byte i; other bytes unchanged; return to IDLE; cop_done=1 for the following cycle only.
REQ-026 palu_cpr_rd_ben=4'h0 with palu_idone=1 (e.g. failed CMOV, unknown class) SHALL still complete and pulse cop_done, with no CPR change.
REQ-027 EXEC with palu_idone=0 SHALL remain in EXEC indefinitely (multi-cycle MUL); no timeout.
REQ-028 flush=1 in EXEC SHALL return to IDLE next cycle with no CPR write and no cop_done, including when palu_idone=1 the same cycle (flush wins).
REQ-029 flush=1 in IDLE SHALL block acceptance that cycle and have no other effect.
REQ-030 Single-cycle PALU op accepted at edge T: palu_ivalid high in cycle T+1, CPR written at edge T+2, cop_done high in cycle T+2, id_ready high in cycle T+2; peak throughput one instruction per two cycles.
REQ-031 dbg_rdata SHALL equal CPR[dbg_addr] combinationally, reflecting writes from the next cycle onward.

Reset
REQ-032 While g_reset=1: state=IDLE, all CPRs=CPR_RESET_VAL, palu_ivalid=0, cop_done=0, all registered operand/field outputs=0, id_ready=0.
REQ-033 Reset asserted in EXEC SHALL abandon the instruction immediately with no CPR write; first accept possible on the first edge after g_reset falls.

Verification
REQ-034 Reset, then dbg_addr sweep 0..15 -> dbg_rdata=32'h0 for every index.
REQ-035 CPR c1=32'h0000_0005, c2=32'h0000_0003; issue ADD.PX pw=32-bit crs1=1, crs2=2, crd=3; model PALU returns ben=4'hF, wdata=32'h8 on cycle T+1 -> c3=32'h8, cop_done single pulse at T+2.
REQ-036 Issue with palu_idone held low 5 cycles then high, ben=4'b0011, wdata=32'hAABB_CCDD, c4 previously 32'h1122_3344 -> c4=32'h1122_CCDD, palu_rs1..3 stable all 6 EXEC cycles.
REQ-037 Same cycle palu_idone=1 and flush=1, ben=4'hF -> no CPR change, no cop_done, id_ready=1 next cycle.
REQ-038 Back-to-back: write c5=32'h7 then immediately read c5 as crs1 of next instruction -> palu_rs1=32'h7.
REQ-039 g_reset asserted mid-EXEC of a MUL -> palu_ivalid=0 immediately, all CPRs=0, no cop_done.

Source files
------------

// File: rtl/scarv_cop_palu_issue.sv
// ---------------------------------------------------------------------------
// scarv_cop_palu_issue
//   Issue stage between the coprocessor decoder and the PALU. Holds the 16
//   coprocessor registers (CPRs), captures a decoded instruction together
//   with its CPR/GPR operands, presents it to the PALU until the PALU reports
//   completion, then merges the byte-enabled writeback into CPR[crd] and
//   pulses cop_done for one cycle.
//
// Ports
//   g_clk, g_reset            clock, asynchronous active-high reset
//   id_valid / id_ready       decoder handshake
//   id_crs1..3, id_crd        CPR source / destination indices
//   id_gpr_rs1, id_imm,
//   id_pw, id_class,
//   id_subclass               decoded instruction fields
//   palu_ivalid               instruction valid to PALU (high in EXEC)
//   palu_idone                PALU completion
//   gpr_rs1, palu_rs1..3,
//   palu_imm/pw/class/subclass registered operands and fields to PALU
//   palu_cpr_rd_ben/wdata     PALU writeback byte enables and data
//   flush                     abandon in-flight instruction / block accept
//   cop_done                  one-cycle completion pulse to the CPU
//   dbg_addr / dbg_rdata      combinational CPR read port
// ---------------------------------------------------------------------------
module scarv_cop_palu_issue #(
    parameter logic [31:0] CPR_RESET_VAL = 32'h0
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [3:0]  id_crs1,
    input  logic [3:0]  id_crs2,
    input  logic [3:0]  id_crs3,
    input  logic [3:0]  id_crd,
    input  logic [31:0] id_gpr_rs1,
    input  logic [31:0] id_imm,
    input  logic [2:0]  id_pw,
    input  logic [2:0]  id_class,
    input  logic [3:0]  id_subclass,
    output logic        palu_ivalid,
    input  logic        palu_idone,
    output logic [31:0] gpr_rs1,
    output logic [31:0] palu_rs1,
    output logic [31:0] palu_rs2,
    output logic [31:0] palu_rs3,
    output logic [31:0] palu_imm,
    output logic [2:0]  palu_pw,
    output logic [2:0]  palu_class,
    output logic [3:0]  palu_subclass,
    input  logic [3:0]  palu_cpr_rd_ben,
    input  logic [31:0] palu_cpr_rd_wdata,
    input  logic        flush,
    output logic        cop_done,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_rdata
);

    localparam int NUM_LANES = 4;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t state_q, state_d;

    logic [15:0][31:0] cpr_q, cpr_d;
    logic [3:0]        crd_q, crd_d;
    logic [31:0]       gpr_rs1_q, gpr_rs1_d;
    logic [31:0]       rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
    logic [31:0]       imm_q, imm_d;
    logic [2:0]        pw_q, pw_d, class_q, class_d;
    logic [3:0]        subclass_q, subclass_d;
    logic              cop_done_q, cop_done_d;
    logic [31:0]       wb_merged;

    // Reset is included so the decoder sees "not ready" for the whole reset.
    assign id_ready = (state_q == IDLE) && !flush && !g_reset;

    // Byte-lane merge of the PALU writeback over the current CPR[crd].
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign wb_merged[8*i +: 8] = palu_cpr_rd_ben[i] ? palu_cpr_rd_wdata[8*i +: 8]
                                                        : cpr_q[crd_q][8*i +: 8];
    end

    always_comb begin
        state_d    = state_q;
        cpr_d      = cpr_q;
        crd_d      = crd_q;
        gpr_rs1_d  = gpr_rs1_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs3_d      = rs3_q;
        imm_d      = imm_q;
        pw_d       = pw_q;
        class_d    = class_q;
        subclass_d = subclass_q;
        cop_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_valid && id_ready) begin
                    // No bypass: a writeback always lands at least one cycle
                    // before the next accept.
                    crd_d      = id_crd;
                    gpr_rs1_d  = id_gpr_rs1;
                    rs1_d      = cpr_q[id_crs1];
                    rs2_d      = cpr_q[id_crs2];
                    rs3_d      = cpr_q[id_crs3];
                    imm_d      = id_imm;
                    pw_d       = id_pw;
                    class_d    = id_class;
                    subclass_d = id_subclass;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (flush) begin
                    // Flush beats a same-cycle completion.
                    state_d = IDLE;
                end else if (palu_idone) begin
                    cpr_d[crd_q] = wb_merged;
                    cop_done_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q    <= IDLE;
            cpr_q      <= {16{CPR_RESET_VAL}};
            crd_q      <= 4'h0;
            gpr_rs1_q  <= 32'h0;
            rs1_q      <= 32'h0;
            rs2_q      <= 32'h0;
            rs3_q      <= 32'h0;
            imm_q      <= 32'h0;
            pw_q       <= 3'h0;
            class_q    <= 3'h0;
            subclass_q <= 4'h0;
            cop_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpr_q      <= cpr_d;
            crd_q      <= crd_d;
            gpr_rs1_q  <= gpr_rs1_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs3_q      <= rs3_d;
            imm_q      <= imm_d;
            pw_q       <= pw_d;
            class_q    <= class_d;
            subclass_q <= subclass_d;
            cop_done_q <= cop_done_d;
        end
    end

    assign palu_ivalid   = (state_q == EXEC);
    assign gpr_rs1       = gpr_rs1_q;
    assign palu_rs1      = rs1_q;
    assign palu_rs2      = rs2_q;
    assign palu_rs3      = rs3_q;
    assign palu_imm      = imm_q;
    assign palu_pw       = pw_q;
    assign palu_class    = class_q;
    assign palu_subclass = subclass_q;
    assign cop_done      = cop_done_q;
    assign dbg_rdata     = cpr_q[dbg_addr];

endmodule

// File: tb/tb_scarv_cop_palu_issue.sv
module tb_scarv_cop_palu_issue;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        id_valid, id_ready;
    logic [3:0]  id_crs1, id_crs2, id_crs3, id_crd;
    logic [31:0] id_gpr_rs1, id_imm;
    logic [2:0]  id_pw, id_class;
    logic [3:0]  id_subclass;
    logic        palu_ivalid, palu_idone;
    logic [31:0] gpr_rs1, palu_rs1, palu_rs2, palu_rs3, palu_imm;
    logic [2:0]  palu_pw, palu_class;
    logic [3:0]  palu_subclass;
    logic [3:0]  palu_cpr_rd_ben;
    logic [31:0] palu_cpr_rd_wdata;
    logic        flush, cop_done;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    always #5 g_clk = ~g_clk;

    scarv_cop_palu_issue dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3), .id_crd(id_crd),
        .id_gpr_rs1(id_gpr_rs1), .id_imm(id_imm), .id_pw(id_pw),
        .id_class(id_class), .id_subclass(id_subclass),
        .palu_ivalid(palu_ivalid), .palu_idone(palu_idone),
        .gpr_rs1(gpr_rs1), .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3),
        .palu_imm(palu_imm), .palu_pw(palu_pw), .palu_class(palu_class),
        .palu_subclass(palu_subclass),
        .palu_cpr_rd_ben(palu_cpr_rd_ben), .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
        .flush(flush), .cop_done(cop_done),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed transaction table.
    typedef struct {
        logic [3:0]  crs1, crs2, crs3, crd;
        logic [31:0] exp_rs1, exp_rs2, exp_rs3;
        int          delay;      // cycles with palu_idone low before completion
        logic        flush_end;  // flush asserted together with palu_idone
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic [31:0] exp_val;    // CPR[crd] after the instruction
        logic        exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic idle_inputs();
        id_valid = 0; flush = 0; palu_idone = 0;
        palu_cpr_rd_ben = 4'h0; palu_cpr_rd_wdata = 32'h0;
    endtask

    // Called at a negedge; returns at the negedge of the cycle after completion.
    task automatic run_vec(input int n, input vec_t v);
        string t;
        t = $sformatf("v%0d", n);
        id_valid = 1; flush = 0;
        id_crs1 = v.crs1; id_crs2 = v.crs2; id_crs3 = v.crs3; id_crd = v.crd;
        id_gpr_rs1 = 32'h100 + n; id_imm = 32'h200 + n;
        id_pw = 3'd4; id_class = 3'd1; id_subclass = 4'(n);
        #1 chk({t, "_id_ready"}, {31'h0, id_ready}, 32'h1);
        @(posedge g_clk); @(negedge g_clk);
        id_valid = 0;
        for (int k = 0; k <= v.delay; k++) begin
            if (k == v.delay) begin
                palu_idone = 1; palu_cpr_rd_ben = v.ben; palu_cpr_rd_wdata = v.wdata;
                flush = v.flush_end;
            end
            #1;
            chk({t, "_ivalid"}, {31'h0, palu_ivalid}, 32'h1);
            chk({t, "_cop_done_exec"}, {31'h0, cop_done}, 32'h0);
            chk({t, "_id_ready_exec"}, {31'h0, id_ready}, 32'h0);
            chk({t, "_rs1"}, palu_rs1, v.exp_rs1);
            chk({t, "_rs2"}, palu_rs2, v.exp_rs2);
            chk({t, "_rs3"}, palu_rs3, v.exp_rs3);
            chk({t, "_gpr"}, gpr_rs1, 32'h100 + n);
            chk({t, "_imm"}, palu_imm, 32'h200 + n);
            chk({t, "_fields"}, {22'h0, palu_pw, palu_class, palu_subclass},
                {22'h0, 3'd4, 3'd1, 4'(n)});
            @(posedge g_clk); @(negedge g_clk);
        end
        idle_inputs();
        dbg_addr = v.crd;
        #1;
        chk({t, "_cop_done"}, {31'h0, cop_done}, {31'h0, v.exp_done});
        chk({t, "_ivalid_after"}, {31'h0, palu_ivalid}, 32'h0);
        chk({t, "_id_ready_after"}, {31'h0, id_ready}, 32'h1);
        chk({t, "_cpr"}, dbg_rdata, v.exp_val);
    endtask

    // Reference model state for the random phase.
    logic [31:0] m_cpr[16];
    bit          m_busy, m_done;
    logic [31:0] m_rs1, m_rs2, m_rs3, m_gpr, m_imm;
    logic [9:0]  m_fields;
    logic [3:0]  m_crd;
    int          waited;

    initial begin
        vecs[0] = '{4'd0, 4'd0, 4'd0, 4'd1, 32'h0, 32'h0, 32'h0, 0, 1'b0, 4'hF, 32'h5, 32'h5, 1'b1};
        vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd2, 32'h0, 32'h0, 32'h0, 0, 1'b0, 4'hF, 32'h3, 32'h3, 1'b1};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd4, 32'h0, 32'h0, 32'h0, 1, 1'b0, 4'hF, 32'h1122_3344, 32'h1122_3344, 1'b1};
        vecs[3] = '{4'd1, 4'd2, 4'd0, 4'd3, 32'h5, 32'h3, 32'h0, 0, 1'b0, 4'hF, 32'h8, 32'h8, 1'b1};
        vecs[4] = '{4'd1, 4'd2, 4'd3, 4'd4, 32'h5, 32'h3, 32'h8, 5, 1'b0, 4'b0011, 32'hAABB_CCDD, 32'h1122_CCDD, 1'b1};
        vecs[5] = '{4'd4, 4'd3, 4'd2, 4'd4, 32'h1122_CCDD, 32'h8, 32'h3, 0, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h1122_CCDD, 1'b0};
        vecs[6] = '{4'd0, 4'd0, 4'd0, 4'd5, 32'h0, 32'h0, 32'h0, 0, 1'b0, 4'hF, 32'h7, 32'h7, 1'b1};
        vecs[7] = '{4'd5, 4'd4, 4'd1, 4'd6, 32'h7, 32'h1122_CCDD, 32'h5, 2, 1'b0, 4'h0, 32'hDEAD_BEEF, 32'h0, 1'b1};

        g_reset = 1; idle_inputs();
        id_crs1 = 0; id_crs2 = 0; id_crs3 = 0; id_crd = 0;
        id_gpr_rs1 = 0; id_imm = 0; id_pw = 0; id_class = 0; id_subclass = 0;
        dbg_addr = 0;
        @(negedge g_clk);
        id_valid = 1;
        #1;
        chk("rst_id_ready", {31'h0, id_ready}, 32'h0);
        chk("rst_ivalid", {31'h0, palu_ivalid}, 32'h0);
        chk("rst_cop_done", {31'h0, cop_done}, 32'h0);
        chk("rst_ops", palu_rs1 | palu_rs2 | palu_rs3 | gpr_rs1 | palu_imm, 32'h0);
        chk("rst_fields", {22'h0, palu_pw, palu_class, palu_subclass}, 32'h0);
        @(negedge g_clk);
        id_valid = 0;
        g_reset = 0;
        for (int a = 0; a < 16; a++) begin
            dbg_addr = 4'(a);
            #1 chk($sformatf("rst_cpr%0d", a), dbg_rdata, 32'h0);
        end
        // Flush in IDLE blocks acceptance.
        id_valid = 1; flush = 1; id_crd = 4'd9;
        #1 chk("idle_flush_ready", {31'h0, id_ready}, 32'h0);
        @(posedge g_clk); @(negedge g_clk);
        idle_inputs();
        #1 chk("idle_flush_no_exec", {31'h0, palu_ivalid}, 32'h0);

        for (int n = 0; n < 8; n++) run_vec(n, vecs[n]);
        @(negedge g_clk);
        #1 chk("done_single_pulse", {31'h0, cop_done}, 32'h0);

        // Reset in the middle of a long EXEC.
        id_valid = 1; id_crs1 = 4'd3; id_crd = 4'd7;
        @(posedge g_clk); @(negedge g_clk);
        id_valid = 0;
        @(posedge g_clk); @(negedge g_clk);
        #1 chk("mul_exec", {31'h0, palu_ivalid}, 32'h1);
        palu_idone = 1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h1234_5678;
        #1 g_reset = 1;
        #1;
        chk("rstmid_ivalid", {31'h0, palu_ivalid}, 32'h0);
        chk("rstmid_cop_done", {31'h0, cop_done}, 32'h0);
        @(posedge g_clk); #1;
        chk("rstmid_cop_done2", {31'h0, cop_done}, 32'h0);
        for (int a = 0; a < 16; a++) begin
            dbg_addr = 4'(a);
            #1 chk($sformatf("rstmid_cpr%0d", a), dbg_rdata, 32'h0);
        end
        @(negedge g_clk);
        idle_inputs();
        g_reset = 0;

        // Randomized phase against the reference model.
        foreach (m_cpr[i]) m_cpr[i] = 32'h0;
        m_busy = 0; m_done = 0; waited = 0;
        for (int c = 0; c < 3000; c++) begin
            id_valid = 1'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            palu_idone = ($urandom_range(0, 2) == 0);
            palu_cpr_rd_ben = 4'($urandom);
            palu_cpr_rd_wdata = $urandom;
            id_crs1 = 4'($urandom); id_crs2 = 4'($urandom);
            id_crs3 = 4'($urandom); id_crd = 4'($urandom);
            id_gpr_rs1 = $urandom; id_imm = $urandom;
            id_pw = 3'($urandom); id_class = 3'($urandom); id_subclass = 4'($urandom);
            dbg_addr = 4'($urandom);
            #1;
            chk("rnd_id_ready", {31'h0, id_ready}, {31'h0, !m_busy && !flush});
            chk("rnd_ivalid", {31'h0, palu_ivalid}, {31'h0, m_busy});
            chk("rnd_cop_done", {31'h0, cop_done}, {31'h0, m_done});
            chk("rnd_dbg", dbg_rdata, m_cpr[dbg_addr]);
            if (m_busy) begin
                chk("rnd_rs1", palu_rs1, m_rs1);
                chk("rnd_rs2", palu_rs2, m_rs2);
                chk("rnd_rs3", palu_rs3, m_rs3);
                chk("rnd_gpr", gpr_rs1, m_gpr);
                chk("rnd_imm", palu_imm, m_imm);
                chk("rnd_fields", {22'h0, palu_pw, palu_class, palu_subclass}, {22'h0, m_fields});
            end
            m_done = 0;
            if (!m_busy) begin
                if (id_valid && !flush) begin
                    m_busy = 1;
                    m_rs1 = m_cpr[id_crs1]; m_rs2 = m_cpr[id_crs2]; m_rs3 = m_cpr[id_crs3];
                    m_gpr = id_gpr_rs1; m_imm = id_imm; m_crd = id_crd;
                    m_fields = {id_pw, id_class, id_subclass};
                end
            end else if (flush) begin
                m_busy = 0;
            end else if (palu_idone) begin
                for (int b = 0; b < 4; b++)
                    if (palu_cpr_rd_ben[b]) m_cpr[m_crd][8*b +: 8] = palu_cpr_rd_wdata[8*b +: 8];
                m_busy = 0;
                m_done = 1;
            end
            @(posedge g_clk); @(negedge g_clk);
        end

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
